// File: rtl/fetch_queue_unit_if.sv
// Bus bundle for fetch_queue_unit: instruction ROM port, execute redirect and decode handshake.
// Decode handshake: an entry moves on any cycle with dec_valid && dec_ready; dec_valid never depends on dec_ready, and the head holds until taken.
interface fetch_queue_unit_if #(
  parameter int XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [31:0]     imem_data;
  logic            imem_valid;
  logic            redirect_en;
  logic [XLEN-1:0] redirect_pc;
  logic            dec_valid;
  logic            dec_ready;
  logic [31:0]     dec_instr;
  logic [XLEN-1:0] dec_pc;
  logic            dec_pred_taken;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_data,
    input  imem_valid,
    input  redirect_en,
    input  redirect_pc,
    output dec_valid,
    input  dec_ready,
    output dec_instr,
    output dec_pc,
    output dec_pred_taken
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_data,
    output imem_valid,
    output redirect_en,
    output redirect_pc,
    input  dec_valid,
    output dec_ready,
    input  dec_instr,
    input  dec_pc,
    input  dec_pred_taken
  );
endinterface

// File: rtl/fetch_queue_unit.sv
// Instruction fetch stage: PC, one-cycle ROM requests, prefetch queue to decode, execute redirects.
// Define STATIC_BTFN_PREDICT_EN to predict backward B-type branches and JAL as taken at push time.
module fetch_queue_unit #(
  parameter int              XLEN        = 32,
  parameter int              QDEPTH      = 4,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter int              INSTR_BYTES = 4
) (
  input  logic                clk,
  input  logic                reset,
  fetch_queue_unit_if.master  fq
);
  localparam int              PW      = $clog2(QDEPTH);
  localparam int              CW      = PW + 1;
  localparam logic [CW:0]     L_DEPTH = (CW+1)'(QDEPTH);
  localparam logic [CW-1:0]   L_FULL  = CW'(QDEPTH);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_req_addr;
  logic [CW-1:0]   r_count;
  logic [PW-1:0]   r_rd_ptr;
  logic [PW-1:0]   r_wr_ptr;
  logic            r_inflight;
  logic            r_drop;
  logic [31:0]     r_q_instr [QDEPTH];
  logic [XLEN-1:0] r_q_pc    [QDEPTH];
  logic [QDEPTH-1:0] r_q_pred;

  logic [CW:0]     w_credit;
  logic            w_issue;
  logic            w_dec_valid;
  logic            w_pop;
  logic            w_push;
  logic            w_pred_taken;
  logic [XLEN-1:0] w_pred_target;
  logic            w_pred_redirect;

  // Entries already queued plus the one response still owed by the ROM must fit.
  assign w_credit    = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};
  assign w_issue     = !reset && !fq.redirect_en && (w_credit < L_DEPTH);
  assign w_dec_valid = !reset && (r_count != '0);
  assign w_pop       = w_dec_valid && fq.dec_ready && !fq.redirect_en;
  // Only a response we actually asked for is accepted; anything else is stale.
  assign w_push      = !reset && !fq.redirect_en && fq.imem_valid && r_inflight && !r_drop;

`ifdef STATIC_BTFN_PREDICT_EN
  logic [6:0]      w_opcode;
  logic [XLEN-1:0] w_b_imm;
  logic [XLEN-1:0] w_j_imm;
  logic            w_is_bwd_b;
  logic            w_is_jal;

  assign w_opcode   = fq.imem_data[6:0];
  assign w_b_imm    = {{(XLEN-12){fq.imem_data[31]}}, fq.imem_data[7], fq.imem_data[30:25],
                       fq.imem_data[11:8], 1'b0};
  assign w_j_imm    = {{(XLEN-20){fq.imem_data[31]}}, fq.imem_data[19:12], fq.imem_data[20],
                       fq.imem_data[30:21], 1'b0};
  assign w_is_bwd_b = (w_opcode == 7'b1100011) && fq.imem_data[31];
  assign w_is_jal   = (w_opcode == 7'b1101111);
  assign w_pred_taken  = w_is_bwd_b || w_is_jal;
  assign w_pred_target = r_req_addr + (w_is_jal ? w_j_imm : w_b_imm);
`else
  assign w_pred_taken  = 1'b0;
  assign w_pred_target = '0;
`endif

  assign w_pred_redirect = w_push && w_pred_taken;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc       <= RESET_PC;
      r_req_addr <= '0;
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_inflight <= 1'b0;
      r_drop     <= 1'b0;
      r_q_pred   <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        r_q_instr[i] <= '0;
        r_q_pc[i]    <= '0;
      end
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_req_addr <= r_pc;
      end
      if (fq.redirect_en) begin
        // Flush wins over any pop or prediction this cycle; decode drops its own copy.
        r_pc     <= fq.redirect_pc;
        r_count  <= '0;
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_drop   <= r_inflight;
      end else begin
        if (w_push) begin
          r_q_instr[r_wr_ptr] <= fq.imem_data;
          r_q_pc[r_wr_ptr]    <= r_req_addr;
          r_q_pred[r_wr_ptr]  <= w_pred_taken;
          r_wr_ptr            <= r_wr_ptr + PW'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + PW'(1);
        end
        r_count <= r_count + {{PW{1'b0}}, w_push} - {{PW{1'b0}}, w_pop};
        if (w_pred_redirect) begin
          // The sequential request issued alongside the prediction is on the wrong path.
          r_pc   <= w_pred_target;
          r_drop <= w_issue;
        end else begin
          if (w_issue) begin
            r_pc <= r_pc + XLEN'(INSTR_BYTES);
          end
          r_drop <= 1'b0;
        end
      end
    end
  end

  assign fq.imem_req       = w_issue;
  assign fq.imem_addr      = r_pc;
  assign fq.dec_valid      = w_dec_valid;
  assign fq.dec_instr      = reset ? '0 : r_q_instr[r_rd_ptr];
  assign fq.dec_pc         = reset ? '0 : r_q_pc[r_rd_ptr];
  assign fq.dec_pred_taken = reset ? 1'b0 : r_q_pred[r_rd_ptr];

  a_no_overflow: assert property (@(posedge clk) disable iff (reset)
    !(w_push && !w_pop && (r_count == L_FULL)));
  a_no_underflow: assert property (@(posedge clk) disable iff (reset)
    !(w_pop && (r_count == '0)));
endmodule

// File: tb/tb_fetch_queue_unit.sv
// Bench for fetch_queue_unit: ROM responder, queue-based reference model checked every cycle, directed scenarios.
module tb_fetch_queue_unit;
  localparam int          XLEN   = 32;
  localparam int          QDEPTH = 4;
  localparam logic [31:0] RST_PC = 32'h100;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        pred;
  } ent_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fetch_queue_unit_if #(.XLEN(XLEN)) fq();

  fetch_queue_unit #(
    .XLEN(XLEN), .QDEPTH(QDEPTH), .RESET_PC(RST_PC), .INSTR_BYTES(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .fq(fq)
  );

  int vectors = 0;
  int miscompares = 0;
  bit branch_rom = 1'b0;
  bit inject_stale = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rom(input logic [31:0] a);
    if (branch_rom && a == 32'h104) return 32'hFE000EE3;
    return {a[19:0], 12'h013};
  endfunction

  // Taken offset from the architectural immediate fields, as plain integers.
  function automatic int pred_off(input logic [31:0] ins);
    if (ins[6:0] == 7'b1101111)
      return (ins[31] ? -(1 << 20) : 0) + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048
             + int'(ins[30:21]) * 2;
    return (ins[31] ? -4096 : 0) + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32
           + int'(ins[11:8]) * 2;
  endfunction

  function automatic bit pred_of(input logic [31:0] ins);
`ifdef STATIC_BTFN_PREDICT_EN
    return (ins[6:0] == 7'b1101111) || (ins[6:0] == 7'b1100011 && ins[31]);
`else
    return (ins === 32'hFFFFFFFF) && 1'b0;
`endif
  endfunction

  // ROM: answers one cycle after each request; can inject an unrequested response.
  logic        rom_pend_v = 1'b0;
  logic [31:0] rom_pend_a = '0;
  always @(negedge clk) begin
    rom_pend_v = fq.imem_req;
    rom_pend_a = fq.imem_addr;
  end
  always @(posedge clk) begin
    #1;
    if (inject_stale) begin
      fq.imem_valid = 1'b1;
      fq.imem_data  = 32'h0BAD0013;
    end else begin
      fq.imem_valid = rom_pend_v;
      fq.imem_data  = rom_pend_v ? rom(rom_pend_a) : 32'h0;
    end
  end

  // Reference model: queue of fetched entries, PC, and the one outstanding request.
  ent_t        m_q[$];
  logic [31:0] m_pc = RST_PC;
  bit          m_flight = 1'b0;
  bit          m_kill = 1'b0;
  logic [31:0] m_flight_addr = '0;

  always @(negedge clk) begin
    bit          exp_req, exp_valid, resp, next_kill;
    logic [31:0] new_addr, ri;
    ent_t        e;
    exp_req   = !reset && !fq.redirect_en && ((m_q.size() + int'(m_flight)) < QDEPTH);
    exp_valid = !reset && (m_q.size() > 0);
    check("imem_req", 32'(fq.imem_req), 32'(exp_req));
    if (exp_req) check("imem_addr", fq.imem_addr, m_pc);
    check("dec_valid", 32'(fq.dec_valid), 32'(exp_valid));
    if (exp_valid) begin
      check("dec_instr", fq.dec_instr, m_q[0].instr);
      check("dec_pc", fq.dec_pc, m_q[0].pc);
      check("dec_pred", 32'(fq.dec_pred_taken), 32'(m_q[0].pred));
    end
    if (reset) begin
      check("rst_instr", fq.dec_instr, 32'h0);
      check("rst_pc", fq.dec_pc, 32'h0);
      check("rst_pred", 32'(fq.dec_pred_taken), 32'h0);
    end
    new_addr = '0;
    if (reset) begin
      m_pc = RST_PC; m_q.delete(); m_flight = 1'b0; m_kill = 1'b0;
    end else if (fq.redirect_en) begin
      m_pc = fq.redirect_pc; m_q.delete(); m_flight = 1'b0; m_kill = 1'b0;
    end else begin
      resp = m_flight && !m_kill;
      next_kill = 1'b0;
      if (exp_valid && fq.dec_ready) void'(m_q.pop_front());
      if (exp_req) begin
        new_addr = m_pc;
        m_pc = m_pc + 32'd4;
      end
      if (resp) begin
        ri = rom(m_flight_addr);
        e.instr = ri; e.pc = m_flight_addr; e.pred = pred_of(ri);
        m_q.push_back(e);
        if (e.pred) begin
          m_pc = m_flight_addr + 32'(pred_off(ri));
          next_kill = exp_req;
        end
      end
      m_flight = exp_req;
      if (exp_req) m_flight_addr = new_addr;
      m_kill = next_kill;
    end
  end

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    fq.redirect_en = 1'b0;
    repeat (2) next_cyc();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    miscompares++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    int reqs;
    fq.redirect_en = 1'b0;
    fq.redirect_pc = '0;
    fq.dec_ready   = 1'b1;
    next_cyc();

    // 1: sequential stream, first entry two cycles after first request.
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      #1;
      check("t1_req", 32'(fq.imem_req), 32'h1);
      check("t1_addr", fq.imem_addr, RST_PC + 32'(4 * i));
      if (i < 2) check("t1_valid0", 32'(fq.dec_valid), 32'h0);
      else begin
        check("t1_valid", 32'(fq.dec_valid), 32'h1);
        check("t1_pc", fq.dec_pc, RST_PC + 32'(4 * (i - 2)));
      end
      next_cyc();
    end

    // 2: decode stalled, queue fills to QDEPTH, then drains in order.
    fq.dec_ready = 1'b0;
    apply_reset();
    reqs = 0;
    repeat (10) begin
      #1;
      if (fq.imem_req) reqs++;
      next_cyc();
    end
    check("t2_reqs", 32'(reqs), 32'd4);
    fq.dec_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t2_valid", 32'(fq.dec_valid), 32'h1);
      check("t2_pc", fq.dec_pc, 32'h100 + 32'(4 * i));
      if (i == 0) check("t2_full_req", 32'(fq.imem_req), 32'h0);
      if (i == 1) check("t2_resume", fq.imem_addr, 32'h110);
      next_cyc();
    end

    // 3: redirect with 3 queued and a response arriving.
    fq.dec_ready = 1'b0;
    apply_reset();
    repeat (4) next_cyc();
    fq.redirect_en = 1'b1;
    fq.redirect_pc = 32'h200;
    #1;
    check("t3_redir_req", 32'(fq.imem_req), 32'h0);
    next_cyc();
    fq.redirect_en = 1'b0;
    fq.dec_ready = 1'b1;
    #1;
    check("t3_flushed", 32'(fq.dec_valid), 32'h0);
    check("t3_addr", fq.imem_addr, 32'h200);
    repeat (2) next_cyc();
    for (int k = 0; k < 5; k++) begin
      #1;
      check("t3_valid", 32'(fq.dec_valid), 32'h1);
      check("t3_pc", fq.dec_pc, 32'h200 + 32'(4 * k));
      next_cyc();
    end

    // 6: reset mid-stream with a full queue plus an unrequested response after release.
    fq.dec_ready = 1'b0;
    apply_reset();
    repeat (6) next_cyc();
    #1;
    check("t6_full", 32'(fq.dec_valid), 32'h1);
    reset = 1'b1;
    inject_stale = 1'b1;
    #1;
    check("t6_rst_valid", 32'(fq.dec_valid), 32'h0);
    check("t6_rst_req", 32'(fq.imem_req), 32'h0);
    next_cyc();
    reset = 1'b0;
    #1;
    inject_stale = 1'b0;
    check("t6_req", 32'(fq.imem_req), 32'h1);
    check("t6_addr", fq.imem_addr, RST_PC);
    check("t6_instr0", fq.dec_instr, 32'h0);
    next_cyc();
    #1;
    check("t6_stale", 32'(fq.dec_valid), 32'h0);
    next_cyc();
    #1;
    check("t6_valid", 32'(fq.dec_valid), 32'h1);
    check("t6_pc", fq.dec_pc, 32'h100);
    check("t6_instr", fq.dec_instr, 32'h00100013);
    next_cyc();

`ifdef STATIC_BTFN_PREDICT_EN
    // 4: backward branch at 0x104 predicted taken back to 0x100.
    branch_rom = 1'b1;
    fq.dec_ready = 1'b1;
    apply_reset();
    repeat (2) next_cyc();
    #1;
    check("t4_seq", fq.imem_addr, 32'h108);
    next_cyc();
    #1;
    check("t4_req", 32'(fq.imem_req), 32'h1);
    check("t4_target", fq.imem_addr, 32'h100);
    check("t4_pc", fq.dec_pc, 32'h104);
    check("t4_pred", 32'(fq.dec_pred_taken), 32'h1);
    next_cyc();
    #1;
    check("t4_killed", 32'(fq.dec_valid), 32'h0);
    next_cyc();

    // 5: execute redirect beats a prediction in the same cycle.
    apply_reset();
    repeat (2) next_cyc();
    fq.redirect_en = 1'b1;
    fq.redirect_pc = 32'h300;
    #1;
    check("t5_redir_req", 32'(fq.imem_req), 32'h0);
    next_cyc();
    fq.redirect_en = 1'b0;
    #1;
    check("t5_addr", fq.imem_addr, 32'h300);
    check("t5_valid", 32'(fq.dec_valid), 32'h0);
    repeat (4) next_cyc();
    branch_rom = 1'b0;
`endif

    repeat (3) next_cyc();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
